// File: rtl/sm_run_ctrl_if.sv
// Dump stream between the run controller and its host.
// Valid/ready handshake; data and index are held while ready is low.
interface sm_run_ctrl_if;
   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_data;
   logic [4:0]  dump_idx;

   modport master (
      output dump_valid,
      output dump_data,
      output dump_idx,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_data,
      input  dump_idx,
      output dump_ready
   );
endinterface

// File: rtl/sm_run_ctrl.sv
// Debug run controller: run/halt/step, breakpoint, register dump.
// Gates the CPU through cpu_en and counts enabled cycles.
module sm_run_ctrl #(
   parameter bit BP_EN_DEFAULT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run_req,
   input  logic          halt_req,
   input  logic          step_req,
   input  logic          dump_req,
   input  logic          bp_set,
   input  logic [31:0]   bp_addr_in,
   input  logic [31:0]   pc,
   output logic          cpu_en,
   output logic [4:0]    dbg_addr,
   input  logic [31:0]   dbg_data,
   sm_run_ctrl_if.master dump,
   output logic [1:0]    state,
   output logic          bp_hit,
   output logic [31:0]   icount
);

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      DUMP = 2'd3
   } runStateT;

   runStateT    curState;
   runStateT    nextState;
   logic [4:0]  dbgAddrQ;
   logic [4:0]  nextDbgAddr;
   logic        bpHitQ;
   logic        nextBpHit;
   logic        skip;
   logic        nextSkip;
   logic [31:0] bpAddr;
   logic        bpEnable;
   logic [31:0] icountQ;
   logic        hit;
   logic        cpuEn;
   logic        dumpValid;

   // skip lets a resume execute the instruction sitting at bpAddr
   assign hit = bpEnable & (pc == bpAddr) & ~skip;

   always_comb begin
      nextState   = curState;
      nextDbgAddr = dbgAddrQ;
      nextBpHit   = bpHitQ;
      nextSkip    = skip;
      cpuEn       = 1'b0;
      dumpValid   = 1'b0;
      unique case (curState)
         HALT: begin
            if (dump_req) begin
               nextState   = DUMP;
               nextDbgAddr = 5'd1;
            end else if (step_req) begin
               nextState = STEP;
            end else if (run_req) begin
               nextState = RUN;
               nextBpHit = 1'b0;
               nextSkip  = 1'b1;
            end
         end
         RUN: begin
            cpuEn    = ~hit;
            nextSkip = 1'b0;
            if (hit)
               nextBpHit = 1'b1;
            if (halt_req || hit)
               nextState = HALT;
         end
         STEP: begin
            cpuEn     = 1'b1;
            nextState = HALT;
         end
         DUMP: begin
            dumpValid = 1'b1;
            if (dump.dump_ready) begin
               if (dbgAddrQ == 5'd31) begin
                  nextState   = HALT;
                  nextDbgAddr = 5'd0;
               end else begin
                  nextDbgAddr = dbgAddrQ + 5'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState <= HALT;
         dbgAddrQ <= 5'd0;
         bpHitQ   <= 1'b0;
         skip     <= 1'b0;
      end else begin
         curState <= nextState;
         dbgAddrQ <= nextDbgAddr;
         bpHitQ   <= nextBpHit;
         skip     <= nextSkip;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         icountQ <= 32'd0;
      end else if (cpuEn) begin
         icountQ <= icountQ + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bpAddr   <= 32'd0;
         bpEnable <= BP_EN_DEFAULT;
      end else if (bp_set) begin
         bpAddr   <= bp_addr_in;
         bpEnable <= 1'b1;
      end
   end

   assign state           = curState;
   assign cpu_en          = cpuEn;
   assign dbg_addr        = dbgAddrQ;
   assign bp_hit          = bpHitQ;
   assign icount          = icountQ;
   assign dump.dump_valid = dumpValid;
   assign dump.dump_data  = dbg_data;
   assign dump.dump_idx   = dbgAddrQ;

endmodule
